// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// Results are sign-corrected once at FINISH; Hi/Lo only move on that edge or on reset.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic             MultS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FINISH, DZERO} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;

  logic               start;
  logic               last;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    start = MultStart | DivStart;
    last  = (cnt == CW'(WIDTH - 1));
    a_neg = MultS & A[WIDTH-1];
    b_neg = MultS & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mult_next = {mult_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left; restore when the trial goes negative.
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (MultStart)     state_next = MULT;
        else if (DivStart) state_next = (B == '0) ? DZERO : DIV;
      end
      MULT, DIV: if (last) state_next = FINISH;
      FINISH, DZERO: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Hi      <= '0;
      Lo      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            Busy    <= 1'b1;
            cnt     <= '0;
            is_div  <= ~MultStart;
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= a_neg & ~MultStart;
            operand <= MultStart ? a_mag : b_mag;
            acc     <= {{WIDTH{1'b0}}, (MultStart ? b_mag : a_mag)};
          end
        end
        MULT: begin
          acc <= mult_next;
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
        end
        FINISH: begin
          if (is_div) begin
            Hi <= rem_fix;
            Lo <= quo_fix;
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        DZERO: begin
          Done    <= 1'b1;
          DivZero <= 1'b1;
          Busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        MultStart = 1'b0;
  logic        DivStart = 1'b0;
  logic        MultS = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, DivZero;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .MultStart(MultStart), .DivStart(DivStart),
    .MultS(MultS), .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done),
    .DivZero(DivZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset && DivZero && !Done) chk("divzero_without_done", 32'(DivZero), 32'(0));
    if (Reset && Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(Done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", Hi, e.hi);
        chk("lo", Lo, e.lo);
        chk("divzero", 32'(DivZero), 32'(e.dz));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(Busy), 32'(0));
      end
    end
  end

  // Called at a negedge; start is seen on the next rising edge and dropped at the following negedge.
  task automatic issue(input logic m, input logic d, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic push,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    MultStart = m;
    DivStart  = d;
    MultS     = s;
    A         = a;
    B         = b;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.dz  = edz;
      e.cyc = cyc + (edz ? 2 : 34);
      sb.push_back(e);
    end
    @(negedge Clock);
    MultStart = 1'b0;
    DivStart  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    logic busy_bad;
    seen     = 1'b0;
    busy_bad = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clock);
      if (Done) seen = 1'b1;
      else if (!Busy) busy_bad = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'(1));
    chk({name, "_busy_while_running"}, 32'(busy_bad), 32'(0));
  endtask

  initial begin
    #1;
    chk("reset_hi", Hi, 32'h0);
    chk("reset_lo", Lo, 32'h0);
    chk("reset_flags", {29'b0, Busy, Done, DivZero}, 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    issue(1, 0, 1, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    chk("busy_after_start", 32'(Busy), 32'(1));
    wait_done("smul");
    @(negedge Clock);
    chk("done_single_pulse", 32'(Done), 32'(0));

    issue(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0);
    wait_done("umul");
    issue(1, 0, 1, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0);
    wait_done("smul_minmin");

    issue(0, 1, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    wait_done("sdiv");
    // back-to-back: new start driven in the Done cycle
    issue(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0);
    wait_done("sdiv_ovf");

    issue(0, 1, 1, 32'd5, 32'd0, 1, 32'h00000000, 32'h80000000, 1);
    wait_done("divzero");

    issue(0, 1, 0, 32'hFFFFFFF9, 32'd2, 1, 32'h00000001, 32'h7FFFFFFC, 0);
    wait_done("udiv");
    issue(0, 1, 1, 32'd7, 32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 0);
    wait_done("sdiv_negdivisor");
    issue(0, 1, 0, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
    wait_done("udiv_small");

    issue(1, 1, 0, 32'd3, 32'd4, 1, 32'h0, 32'd12, 0);
    repeat (9) @(negedge Clock);
    chk("busy_before_ignored_start", 32'(Busy), 32'(1));
    DivStart = 1'b1;
    A        = 32'd100;
    B        = 32'd7;
    @(negedge Clock);
    DivStart = 1'b0;
    wait_done("priority");
    repeat (40) @(negedge Clock);

    issue(1, 0, 0, 32'd1234, 32'd5678, 0, 32'h0, 32'h0, 0);
    repeat (14) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("abort_hi", Hi, 32'h0);
    chk("abort_lo", Lo, 32'h0);
    chk("abort_flags", {29'b0, Busy, Done, DivZero}, 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (40) @(negedge Clock);
    chk("idle_after_abort", {30'b0, Busy, Done}, 32'h0);

    issue(1, 0, 0, 32'd6, 32'd7, 1, 32'h0, 32'd42, 0);
    wait_done("recover");
    repeat (5) @(negedge Clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide datapath unit, directly downstream of the multicycle control FSM.
- Consumes the control's mult start, div start and signedness flags, plus operands from regs A/B.
- Produces 64-bit products and quotient/remainder pairs on Hi/Lo outputs, which the control then commits to the HI/LO registers.
- Reports completion and divide-by-zero so the control can leave its wait state or raise an exception.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH split across Hi/Lo; iteration count equals WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- MultStart  input  1  start-multiply request, sampled only in IDLE.
- DivStart  input  1  start-divide request, sampled only in IDLE.
- MultS  input  1  1 = signed operation, 0 = unsigned; sampled with the start.
- A  input  WIDTH  multiplicand / dividend; sampled with the start.
- B  input  WIDTH  multiplier / divisor; sampled with the start.
- Hi  output  WIDTH  multiply: product[2W-1:W]; divide: remainder.
- Lo  output  WIDTH  multiply: product[W-1:0]; divide: quotient.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  divide-by-zero flag, pulses together with Done.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; Hi=0, Lo=0, Busy=0, Done=0, DivZero=0; internal counter and accumulators cleared.
- Reset asserted mid-operation aborts the operation. No Done is produced and no partial result reaches Hi/Lo.
- FSM states: IDLE, MULT, DIV, FINISH, DZERO.
- IDLE:
  - Start accepted on rising edge E0 when MultStart or DivStart is 1.
  - Both asserted together: multiply wins, divide is dropped.
  - At E0 the unit latches A, B and MultS and converts operands to magnitudes if signed. It records the result signs and sets Busy=1.
  - State then goes to MULT; to DIV if divisor nonzero; to DZERO if divisor is 0.
- MULT: shift-add of magnitudes, one bit per cycle, WIDTH cycles (edges E1..EW), then FINISH.
- DIV: restoring division of magnitudes, one quotient bit per cycle, WIDTH cycles (edges E1..EW), then FINISH.
- FINISH, one cycle:
  - At edge E(W+1), Hi/Lo are loaded with the sign-corrected result.
  - Done=1 for exactly that following cycle; Busy=0; state returns to IDLE.
- DZERO:
  - At E1, Done=1 and DivZero=1 for one cycle; Busy=0; state returns to IDLE.
  - Hi/Lo keep their previous values.
- Latency: WIDTH+1 edges from accepted start to Done (33 for WIDTH=32). Divide-by-zero takes 1 edge.
- Back-to-back: a start is accepted in the cycle Done is high, since the FSM is already in IDLE.
- Starts while Busy=1 are ignored. Operand changes while Busy=1 have no effect.
- Signed multiply: product negated if the operand signs differ. Full 2W-bit two's complement result; no overflow is possible.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Quotient negated if the signs differ.
  - Overflow case: most-negative / -1 gives Lo=0x80000000, Hi=0, with no flag.
- Unsigned: no sign conversion; operands are treated as WIDTH-bit unsigned.
- Hi/Lo change only at FINISH edges and at reset; they hold otherwise.
- Done and DivZero are never high outside their single pulse cycle.

Test Plan:
- Signed mult: MultS=1, A=7, B=0xFFFFFFFD (-3), MultStart 1 cycle -> after 33 edges Done=1 for 1 cycle; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for edges 1..32.
- Unsigned mult: MultS=0, A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- Signed div:
  - A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
  - Then A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivZero=0.
- Div by zero: A=5, B=0, DivStart -> next cycle Done=1, DivZero=1; Hi/Lo unchanged from the previous result; Busy=0.
- Busy/priority: MultStart and DivStart asserted together with A=3, B=4 -> product Hi=0, Lo=12. DivStart pulsed at cycle 10 with new operands is ignored, and only one Done is produced.
- Reset mid-op: Reset=0 at cycle 15 of a multiply -> Hi=Lo=0, Busy=0, Done=0 immediately; after release, no Done until a new start.
